rob_commit: RTL and testbench
=============================

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 ROB_DEPTH, 16, entry count; SHALL equal 16 (4-bit tags); other values unsupported.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 rdy  in  1  global enable; when low, all state and outputs SHALL hold.
REQ-005 alloc_valid  in  1  dispatch requests an entry this cycle.
REQ-006 alloc_rd  in  5  destination register of dispatched instruction.
REQ-007 alloc_no_rd  in  1  dispatched instruction is branch/store (no register write).
REQ-008 alloc_tag  out  4  combinational tail index, the tag given to the next allocation.
REQ-009 rob_full  out  1  combinational, high when count==16.
REQ-010 cdb_valid  in  1  execution result broadcast.
REQ-011 cdb_tag  in  4  tag of broadcast result.
REQ-012 cdb_value  in  32  result value.
REQ-013 cdb_mispredict  in  1  broadcast instruction is a mispredicted branch.
REQ-014 register_update_flag  out  1  registered; commit writes register file this cycle.
REQ-015 register_commit_dest  out  5  registered; committed rd.
REQ-016 register_commit_value  out  32  registered; committed value.
REQ-017 rename_of_commit_ins  out  4  registered; tag of committed entry.
REQ-018 register_flush  out  1  registered one-cycle flush pulse to register file and pipeline.

Function
REQ-019 Storage: 16 entries of {busy, ready, no_rd, mispredict, rd[4:0], value[31:0]}; head, tail 4-bit wrapping 15->0; count 5-bit, 0..16.
REQ-020 Allocate: alloc_valid && !rob_full -> entry[tail] busy=1, ready=0, mispredict=0, rd/no_rd stored; tail+1; alloc while full SHALL be ignored with no state change.
REQ-021 Writeback: cdb_valid && entry[cdb_tag].busy -> ready=1, value=cdb_value, mispredict=cdb_mispredict; writeback to non-busy entry ignored.
REQ-022 Commit: count>0 && entry[head].ready (registered state, not same-cycle CDB) -> at most one commit per cycle; entry busy=0; head+1; count-1.
REQ-023 Commit output: next cycle register_update_flag=1 iff !no_rd && rd!=0, with dest=rd, value, rename_of_commit_ins=old head; otherwise flag=0; dest/value/tag SHALL hold when flag=0.
REQ-024 Mispredict: committing entry with mispredict=1 -> register_flush=1 for exactly the next cycle; all busy cleared; head=tail=0; count=0; no register update.
REQ-025 Flush priority: same-cycle alloc and writeback ignored when flush commit occurs.
REQ-026 Simultaneous alloc+commit: count unchanged, both pointers advance; full ROB with commit: alloc still rejected (rob_full uses pre-commit count).
REQ-027 Latency: CDB writeback to head -> earliest register_update_flag 2 cycles later.

Reset
REQ-028 rst: head=tail=0, count=0, all busy/ready=0, register_update_flag=0, register_flush=0, register_commit_dest=0, register_commit_value=0, rename_of_commit_ins=0.
REQ-029 rst mid-operation SHALL discard all entries with no commit or flush pulse emitted; rst overrides rdy.

Configuration
REQ-030 ROB_PERF_CNT_EN defined: adds output commit_count[31:0], reset 0, +1 per commit (including no-rd and mispredict), wraps at 2^32.
REQ-031 ROB_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset, alloc rd=5 (tag 0), CDB tag0 value 0x1234 -> 2 cycles later flag=1, dest=5, value=0x1234, rename=0.
REQ-033 Alloc 16 entries -> rob_full=1; 17th alloc ignored, alloc_tag stays 0; commit one -> rob_full=0 next cycle.
REQ-034 Alloc tags 0,1; CDB tag1 then tag0 -> commits in order tag0 then tag1 on consecutive cycles.
REQ-035 Alloc branch (tag0) + rd=7 (tag1); CDB tag0 mispredict=1 -> register_flush one cycle, no update for tag1, count=0, alloc_tag=0.
REQ-036 Alloc rd=0 and store; both written back -> two commits, register_update_flag stays 0; with ROB_PERF_CNT_EN commit_count=2.
REQ-037 rdy=0 during pending CDB-ready head -> no commit; rdy=1 -> commit proceeds unchanged.

Source files
------------

// File: rtl/rob_commit_if.sv
// Dispatch, CDB and commit signals of the reorder buffer.
// The testbench drives the master side and rob_commit uses the slave side.
interface rob_commit_if;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_no_rd;
  logic [3:0]  alloc_tag;
  logic        rob_full;

  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_mispredict;

  logic        register_update_flag;
  logic [4:0]  register_commit_dest;
  logic [31:0] register_commit_value;
  logic [3:0]  rename_of_commit_ins;
  logic        register_flush;

  modport master (
    output alloc_valid, alloc_rd, alloc_no_rd,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
    input  alloc_tag, rob_full,
    input  register_update_flag, register_commit_dest, register_commit_value,
    input  rename_of_commit_ins, register_flush
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_no_rd,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict,
    output alloc_tag, rob_full,
    output register_update_flag, register_commit_dest, register_commit_value,
    output rename_of_commit_ins, register_flush
  );
endinterface

// File: rtl/rob_commit.sv
// 16-entry reorder buffer: in-order commit, CDB writeback and flush on a mispredicted branch.
// Defining ROB_PERF_CNT_EN adds the commit_count output, which counts every commit.
module rob_commit (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]  commit_count,
`endif
  rob_commit_if.slave  rob
);
  localparam int ROB_DEPTH = 16;

  logic [ROB_DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [ROB_DEPTH-1:0] noRd_q, noRd_d, mispred_q, mispred_d;
  logic [4:0]           rd_q    [ROB_DEPTH];
  logic [4:0]           rd_d    [ROB_DEPTH];
  logic [31:0]          value_q [ROB_DEPTH];
  logic [31:0]          value_d [ROB_DEPTH];
  logic [3:0]           head_q, head_d, tail_q, tail_d;
  logic [4:0]           count_q, count_d;

  logic                 updFlag_q, updFlag_d, flush_q, flush_d;
  logic [4:0]           commitDest_q, commitDest_d;
  logic [31:0]          commitValue_q, commitValue_d;
  logic [3:0]           commitTag_q, commitTag_d;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]          commitCount_q, commitCount_d;
`endif

  logic robFull, doAlloc, doWb, doCommit, flushCommit;

  // Commit looks only at registered readiness, so a CDB result needs one cycle before it can retire.
  assign robFull     = (count_q == 5'd16);
  assign doCommit    = (count_q != 5'd0) && busy_q[head_q] && ready_q[head_q];
  assign flushCommit = doCommit && mispred_q[head_q];
  assign doAlloc     = rob.alloc_valid && !robFull;
  assign doWb        = rob.cdb_valid && busy_q[rob.cdb_tag];

  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    noRd_d        = noRd_q;
    mispred_d     = mispred_q;
    rd_d          = rd_q;
    value_d       = value_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    updFlag_d     = updFlag_q;
    flush_d       = flush_q;
    commitDest_d  = commitDest_q;
    commitValue_d = commitValue_q;
    commitTag_d   = commitTag_q;
`ifdef ROB_PERF_CNT_EN
    commitCount_d = commitCount_q;
`endif
    if (rdy) begin
      updFlag_d = 1'b0;
      flush_d   = 1'b0;
      if (doWb) begin
        ready_d[rob.cdb_tag]   = 1'b1;
        value_d[rob.cdb_tag]   = rob.cdb_value;
        mispred_d[rob.cdb_tag] = rob.cdb_mispredict;
      end
      if (doCommit) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + 4'd1;
`ifdef ROB_PERF_CNT_EN
        commitCount_d   = commitCount_q + 32'd1;
`endif
        if (!noRd_q[head_q] && rd_q[head_q] != 5'd0 && !mispred_q[head_q]) begin
          updFlag_d     = 1'b1;
          commitDest_d  = rd_q[head_q];
          commitValue_d = value_q[head_q];
          commitTag_d   = head_q;
        end
      end
      if (doAlloc) begin
        busy_d[tail_q]    = 1'b1;
        ready_d[tail_q]   = 1'b0;
        mispred_d[tail_q] = 1'b0;
        noRd_d[tail_q]    = rob.alloc_no_rd;
        rd_d[tail_q]      = rob.alloc_rd;
        tail_d            = tail_q + 4'd1;
      end
      count_d = count_q + 5'(doAlloc) - 5'(doCommit);
      // A mispredict squashes everything, including this cycle's allocation and writeback.
      if (flushCommit) begin
        flush_d = 1'b1;
        busy_d  = '0;
        ready_d = '0;
        head_d  = 4'd0;
        tail_d  = 4'd0;
        count_d = 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      ready_q       <= '0;
      noRd_q        <= '0;
      mispred_q     <= '0;
      rd_q          <= '{default: '0};
      value_q       <= '{default: '0};
      head_q        <= 4'd0;
      tail_q        <= 4'd0;
      count_q       <= 5'd0;
      updFlag_q     <= 1'b0;
      flush_q       <= 1'b0;
      commitDest_q  <= 5'd0;
      commitValue_q <= 32'd0;
      commitTag_q   <= 4'd0;
`ifdef ROB_PERF_CNT_EN
      commitCount_q <= 32'd0;
`endif
    end else begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      noRd_q        <= noRd_d;
      mispred_q     <= mispred_d;
      rd_q          <= rd_d;
      value_q       <= value_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      updFlag_q     <= updFlag_d;
      flush_q       <= flush_d;
      commitDest_q  <= commitDest_d;
      commitValue_q <= commitValue_d;
      commitTag_q   <= commitTag_d;
`ifdef ROB_PERF_CNT_EN
      commitCount_q <= commitCount_d;
`endif
    end
  end

  assign rob.alloc_tag             = tail_q;
  assign rob.rob_full              = robFull;
  assign rob.register_update_flag  = updFlag_q;
  assign rob.register_commit_dest  = commitDest_q;
  assign rob.register_commit_value = commitValue_q;
  assign rob.rename_of_commit_ins  = commitTag_q;
  assign rob.register_flush        = flush_q;
`ifdef ROB_PERF_CNT_EN
  assign commit_count              = commitCount_q;
`endif
endmodule

// File: tb/tb_rob_commit.sv
// Testbench for rob_commit: directed scenarios followed by random traffic, all checked against a
// program-order queue model of the reorder buffer. Covers the ROB_PERF_CNT_EN build as well.
module tb_rob_commit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy;
  rob_commit_if rob ();
`ifdef ROB_PERF_CNT_EN
  logic [31:0] commit_count;
`endif

  rob_commit dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
`ifdef ROB_PERF_CNT_EN
    .commit_count (commit_count),
`endif
    .rob          (rob)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic        noRd;
    logic        ready;
    logic        mis;
    logic [31:0] val;
  } entry_t;

  // Model: the live instructions, oldest first, plus the values the registered outputs should show.
  entry_t      mQ[$];
  logic [3:0]  mTail;
  logic        mFlag, mFlush;
  logic [4:0]  mDest;
  logic [31:0] mVal;
  logic [3:0]  mTag;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] mCount;
`endif
  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      $error("[TB] assertion on %s", name);
    end
  endtask

  task automatic modelStep(input bit r, input bit en, input bit av, input logic [4:0] ard,
                           input bit anr, input bit cv, input logic [3:0] ct,
                           input logic [31:0] cval, input bit cm);
    bit     full;
    bit     commit;
    entry_t e;
    if (r) begin
      mQ.delete();
      mTail = 4'd0; mFlag = 1'b0; mFlush = 1'b0;
      mDest = 5'd0; mVal = 32'd0; mTag = 4'd0;
`ifdef ROB_PERF_CNT_EN
      mCount = 32'd0;
`endif
    end else if (en) begin
      full   = (mQ.size() == 16);
      commit = (mQ.size() > 0) && mQ[0].ready;
      mFlag  = 1'b0;
      mFlush = 1'b0;
      if (commit) begin
        e = mQ.pop_front();
`ifdef ROB_PERF_CNT_EN
        mCount = mCount + 32'd1;
`endif
        if (e.mis) begin
          mFlush = 1'b1;
          mQ.delete();
          mTail = 4'd0;
        end else if (!e.noRd && e.rd != 5'd0) begin
          mFlag = 1'b1; mDest = e.rd; mVal = e.val; mTag = e.tag;
        end
      end
      if (!mFlush) begin
        if (cv) begin
          foreach (mQ[i]) begin
            if (mQ[i].tag == ct) begin
              e = mQ[i];
              e.ready = 1'b1; e.val = cval; e.mis = cm;
              mQ[i] = e;
            end
          end
        end
        if (av && !full) begin
          e.tag = mTail; e.rd = ard; e.noRd = anr; e.ready = 1'b0; e.mis = 1'b0; e.val = 32'd0;
          mQ.push_back(e);
          mTail = mTail + 4'd1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    check("flag",     32'(rob.register_update_flag),  32'(mFlag));
    check("flush",    32'(rob.register_flush),        32'(mFlush));
    check("dest",     32'(rob.register_commit_dest),  32'(mDest));
    check("value",    rob.register_commit_value,      mVal);
    check("rename",   32'(rob.rename_of_commit_ins),  32'(mTag));
    check("tag_post", 32'(rob.alloc_tag),             32'(mTail));
    check("full_post", 32'(rob.rob_full),             32'(mQ.size() == 16));
`ifdef ROB_PERF_CNT_EN
    check("commit_count", commit_count, mCount);
`endif
  endtask

  // One clock: drive inputs, check the combinational outputs, step the model, then check after the edge.
  task automatic applyStimulus(input bit r, input bit en, input bit av, input logic [4:0] ard,
                               input bit anr, input bit cv, input logic [3:0] ct,
                               input logic [31:0] cval, input bit cm);
    rst = r; rdy = en;
    rob.alloc_valid = av; rob.alloc_rd = ard; rob.alloc_no_rd = anr;
    rob.cdb_valid = cv; rob.cdb_tag = ct; rob.cdb_value = cval; rob.cdb_mispredict = cm;
    #1;
    check("alloc_tag", 32'(rob.alloc_tag), 32'(mTail));
    check("rob_full",  32'(rob.rob_full),  32'(mQ.size() == 16));
    modelStep(r, en, av, ard, anr, cv, ct, cval, cm);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(1, 1, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0);
  endtask
  task automatic idle(input bit en = 1);
    applyStimulus(0, en, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0);
  endtask
  task automatic alloc(input logic [4:0] ard, input bit anr);
    applyStimulus(0, 1, 1, ard, anr, 0, 4'd0, 32'd0, 0);
  endtask
  task automatic cdb(input logic [3:0] ct, input logic [31:0] cval, input bit cm);
    applyStimulus(0, 1, 0, 5'd0, 0, 1, ct, cval, cm);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    rob.alloc_valid = 1'b0; rob.alloc_rd = 5'd0; rob.alloc_no_rd = 1'b0;
    rob.cdb_valid = 1'b0; rob.cdb_tag = 4'd0; rob.cdb_value = 32'd0; rob.cdb_mispredict = 1'b0;
    modelStep(1, 1, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0);
    @(posedge clk);
    #1;
    checkOutput();

    // Basic writeback-to-commit latency
    doReset();
    alloc(5'd5, 0);
    cdb(4'd0, 32'h1234, 0);
    check("lat_early_flag", 32'(rob.register_update_flag), 32'd0);
    idle();
    check("lat_flag",   32'(rob.register_update_flag), 32'd1);
    check("lat_dest",   32'(rob.register_commit_dest), 32'd5);
    check("lat_value",  rob.register_commit_value,     32'h1234);
    check("lat_rename", 32'(rob.rename_of_commit_ins), 32'd0);

    // Full ROB: further allocations rejected until a commit frees space
    doReset();
    for (int i = 0; i < 16; i++) alloc(5'(i + 1), 0);
    check("full_set", 32'(rob.rob_full), 32'd1);
    check("full_tag", 32'(rob.alloc_tag), 32'd0);
    alloc(5'd30, 0);
    check("full_17th_tag", 32'(rob.alloc_tag), 32'd0);
    check("full_17th_full", 32'(rob.rob_full), 32'd1);
    cdb(4'd0, 32'hA5A5_0000, 0);
    applyStimulus(0, 1, 1, 5'd9, 0, 0, 4'd0, 32'd0, 0);
    check("full_cleared", 32'(rob.rob_full), 32'd0);
    check("full_commit_dest", 32'(rob.register_commit_dest), 32'd1);

    // Out-of-order writeback still commits in order
    doReset();
    alloc(5'd3, 0);
    alloc(5'd4, 0);
    cdb(4'd1, 32'hBBBB, 0);
    cdb(4'd0, 32'hAAAA, 0);
    idle();
    check("order_first_tag", 32'(rob.rename_of_commit_ins), 32'd0);
    check("order_first_val", rob.register_commit_value, 32'hAAAA);
    idle();
    check("order_second_tag", 32'(rob.rename_of_commit_ins), 32'd1);
    check("order_second_val", rob.register_commit_value, 32'hBBBB);

    // Mispredicted branch flushes younger work
    doReset();
    alloc(5'd0, 1);
    alloc(5'd7, 0);
    cdb(4'd1, 32'h7777, 0);
    cdb(4'd0, 32'h0, 1);
    idle();
    check("mis_flush", 32'(rob.register_flush), 32'd1);
    check("mis_flag",  32'(rob.register_update_flag), 32'd0);
    check("mis_tag",   32'(rob.alloc_tag), 32'd0);
    idle();
    check("mis_flush_drop", 32'(rob.register_flush), 32'd0);
    check("mis_no_update",  32'(rob.register_update_flag), 32'd0);

    // Commits that write no register
    doReset();
    alloc(5'd0, 0);
    alloc(5'd9, 1);
    cdb(4'd0, 32'h11, 0);
    cdb(4'd1, 32'h22, 0);
    idle();
    check("nord_flag0", 32'(rob.register_update_flag), 32'd0);
    idle();
    check("nord_flag1", 32'(rob.register_update_flag), 32'd0);
`ifdef ROB_PERF_CNT_EN
    check("nord_count", commit_count, 32'd2);
`endif

    // Global enable holds everything, including a pending commit and the output registers
    doReset();
    alloc(5'd12, 0);
    cdb(4'd0, 32'hCAFE, 0);
    idle(0);
    idle(0);
    check("stall_flag", 32'(rob.register_update_flag), 32'd0);
    idle();
    check("stall_commit", 32'(rob.register_update_flag), 32'd1);
    check("stall_value",  rob.register_commit_value, 32'hCAFE);
    idle(0);
    check("stall_hold", 32'(rob.register_update_flag), 32'd1);

    // Reset with a ready head and rdy low: nothing commits
    alloc(5'd6, 0);
    cdb(4'd1, 32'hDEAD, 0);
    applyStimulus(1, 0, 0, 5'd0, 0, 0, 4'd0, 32'd0, 0);
    check("rst_flag", 32'(rob.register_update_flag), 32'd0);
    idle();
    check("rst_no_commit", 32'(rob.register_update_flag), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit          r, en, av, anr, cv, cm;
      logic [4:0]  ard;
      logic [3:0]  ct;
      logic [31:0] cval;
      r    = ($urandom_range(0, 149) == 0);
      en   = ($urandom_range(0, 9) != 0);
      av   = ($urandom_range(0, 9) < 6);
      ard  = 5'($urandom);
      anr  = ($urandom_range(0, 4) == 0);
      cv   = ($urandom_range(0, 9) < 7);
      cm   = ($urandom_range(0, 11) == 0);
      cval = $urandom;
      if (mQ.size() > 0 && $urandom_range(0, 3) != 0)
        ct = mQ[$urandom_range(0, mQ.size() - 1)].tag;
      else
        ct = 4'($urandom);
      applyStimulus(r, en, av, ard, anr, cv, ct, cval, cm);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
